results_streamer: RTL and testbench

- Parametrised successor to the current results sender.
- Reads solver results (T values, then the X vectors per T) from the result RAM through one synchronous read port.
- Serialises each DATA_WIDTH word into BUS_WIDTH beats on a ready/valid CPU bus with backpressure.
- Sits between the result RAM and the IO/CPU interface and is started by the IO controller once solving completes.

---
 rtl/results_io_pkg.sv | 26 ++
 rtl/beat_serializer.sv | 75 +++++++
 rtl/results_streamer.sv | 191 +++++++++++++++++++
 tb/tb_results_streamer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/results_io_pkg.sv
// Shared definitions for the result streaming path: FSM encoding, default RAM map, beat math.
package results_io_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RD_NT = 3'd1;
  localparam state_t S_RD_NX = 3'd2;
  localparam state_t S_CHK   = 3'd3;
  localparam state_t S_FETCH = 3'd4;
  localparam state_t S_LOAD  = 3'd5;
  localparam state_t S_SEND  = 3'd6;
  localparam state_t S_DONE  = 3'd7;

  localparam int unsigned DEF_NUM_T_ADDR  = 1;
  localparam int unsigned DEF_NUM_X_ADDR  = 2;
  localparam int unsigned DEF_T_BASE_ADDR = 3;
  localparam int unsigned DEF_X_BASE_ADDR = 10;

  // Number of bus beats needed to carry one RAM word.
  function automatic int unsigned beats_f(input int unsigned data_w, input int unsigned bus_w);
    return data_w / bus_w;
  endfunction

endpackage

// File: rtl/beat_serializer.sv
// Splits one RAM word into low-slice-first bus beats with ready/valid handshaking.
module beat_serializer
  import results_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned BUS_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  last_word,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  bus_ready,
  output logic [BUS_WIDTH-1:0]  bus_data,
  output logic                  bus_valid,
  output logic                  bus_last,
  output logic                  word_done_c
);

  localparam int unsigned BEATS  = beats_f(DATA_WIDTH, BUS_WIDTH);
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  hs_c, final_beat_c;

  assign hs_c         = valid_q & bus_ready;
  assign final_beat_c = (beat_q == BEAT_W'(BEATS - 1));
  assign word_done_c  = hs_c & final_beat_c;

  // Load a fresh word, or shift the next slice down after each accepted beat.
  always_comb begin
    word_d  = word_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      word_d  = word_in;
      beat_d  = '0;
      valid_d = 1'b1;
      last_d  = last_word && (BEATS == 1);
    end else if (hs_c) begin
      if (final_beat_c) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        word_d  = word_q >> BUS_WIDTH;
        beat_d  = beat_q + 1'b1;
        last_d  = last_word && (beat_d == BEAT_W'(BEATS - 1));
      end
    end
  end

  // Word, beat and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus_data  = word_q[BUS_WIDTH-1:0];
  assign bus_valid = valid_q;
  assign bus_last  = last_q;

endmodule

// File: rtl/results_streamer.sv
// Streams solver results (T values, each followed by its X vector) from the result RAM onto the CPU bus.
module results_streamer
  import results_io_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 13,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned COUNT_WIDTH   = 8,
  parameter int unsigned NUM_T_ADDR    = DEF_NUM_T_ADDR,
  parameter int unsigned NUM_X_ADDR    = DEF_NUM_X_ADDR,
  parameter int unsigned T_BASE_ADDR   = DEF_T_BASE_ADDR,
  parameter int unsigned X_BASE_ADDR   = DEF_X_BASE_ADDR
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  output logic                     Busy,
  output logic                     Done,
  output logic                     Error,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic                     RAM_Read_En,
  input  logic [DATA_WIDTH-1:0]    RAM_Data,
  output logic [BUS_WIDTH-1:0]     Bus_Data,
  output logic                     Bus_Valid,
  input  logic                     Bus_Ready,
  output logic                     Bus_Last
);

  state_t                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   nt_q, nt_d, nx_q, nx_d;
  logic [COUNT_WIDTH-1:0]   t_cnt_q, t_cnt_d, j_q, j_d;
  logic                     nt_ovf_q, nt_ovf_d;
  logic                     is_x_q, is_x_d;
  logic [ADDRESS_WIDTH-1:0] t_ptr_q, t_ptr_d, x_ptr_q, x_ptr_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     rd_en_q, rd_en_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                     ovf_c, last_word_c, word_done_c;

  assign ovf_c = (RAM_Data >> COUNT_WIDTH) != '0;
  assign last_word_c = (t_cnt_q == nt_q - COUNT_WIDTH'(1)) &&
                       (is_x_q ? (j_q == nx_q - COUNT_WIDTH'(1)) : (nx_q == '0));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (Start) state_d = S_RD_NT;
      S_RD_NT: state_d = S_RD_NX;
      S_RD_NX: state_d = S_CHK;
      S_CHK: begin
        if (nt_ovf_q || ovf_c) state_d = S_DONE;
        else if (nt_q == '0)   state_d = S_DONE;
        else                   state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND:  if (word_done_c) state_d = last_word_c ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Count capture, overflow flag and word-walk pointers (running X pointer, no multiply).
  always_comb begin
    nt_d     = nt_q;
    nt_ovf_d = nt_ovf_q;
    nx_d     = nx_q;
    t_cnt_d  = t_cnt_q;
    j_d      = j_q;
    is_x_d   = is_x_q;
    t_ptr_d  = t_ptr_q;
    x_ptr_d  = x_ptr_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: if (Start) error_d = 1'b0;
      S_RD_NX: begin
        nt_d     = RAM_Data[COUNT_WIDTH-1:0];
        nt_ovf_d = ovf_c;
      end
      S_CHK: begin
        nx_d    = RAM_Data[COUNT_WIDTH-1:0];
        t_cnt_d = '0;
        j_d     = '0;
        is_x_d  = 1'b0;
        t_ptr_d = ADDRESS_WIDTH'(T_BASE_ADDR);
        x_ptr_d = ADDRESS_WIDTH'(X_BASE_ADDR);
        if (nt_ovf_q || ovf_c) error_d = 1'b1;
      end
      S_SEND: begin
        if (word_done_c && !last_word_c) begin
          if (!is_x_q) begin
            if (nx_q == '0) begin
              t_cnt_d = t_cnt_q + 1'b1;
              t_ptr_d = t_ptr_q + 1'b1;
            end else begin
              is_x_d = 1'b1;
              j_d    = '0;
            end
          end else begin
            x_ptr_d = x_ptr_q + 1'b1;
            if (j_q == nx_q - COUNT_WIDTH'(1)) begin
              is_x_d  = 1'b0;
              j_d     = '0;
              t_cnt_d = t_cnt_q + 1'b1;
              t_ptr_d = t_ptr_q + 1'b1;
            end else begin
              j_d = j_q + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    case (state_d)
      S_RD_NT: begin rd_en_d = 1'b1; addr_d = ADDRESS_WIDTH'(NUM_T_ADDR); end
      S_RD_NX: begin rd_en_d = 1'b1; addr_d = ADDRESS_WIDTH'(NUM_X_ADDR); end
      S_FETCH: begin rd_en_d = 1'b1; addr_d = is_x_d ? x_ptr_d : t_ptr_d; end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      nt_q     <= '0;
      nt_ovf_q <= 1'b0;
      nx_q     <= '0;
      t_cnt_q  <= '0;
      j_q      <= '0;
      is_x_q   <= 1'b0;
      t_ptr_q  <= '0;
      x_ptr_q  <= '0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      nt_q     <= nt_d;
      nt_ovf_q <= nt_ovf_d;
      nx_q     <= nx_d;
      t_cnt_q  <= t_cnt_d;
      j_q      <= j_d;
      is_x_q   <= is_x_d;
      t_ptr_q  <= t_ptr_d;
      x_ptr_q  <= x_ptr_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
    end
  end

  beat_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_ser (
    .clk         (CLK),
    .rst         (RST),
    .load        (state_q == S_LOAD),
    .last_word   (last_word_c),
    .word_in     (RAM_Data),
    .bus_ready   (Bus_Ready),
    .bus_data    (Bus_Data),
    .bus_valid   (Bus_Valid),
    .bus_last    (Bus_Last),
    .word_done_c (word_done_c)
  );

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Error       = error_q;
  assign RAM_Address = addr_q;
  assign RAM_Read_En = rd_en_q;

endmodule

// File: tb/tb_results_streamer.sv
// Scoreboard bench: a 64/32 instance and a 32/32 instance share clock and reset; sel picks the active one.
module tb_results_streamer;

  localparam int unsigned AW = 13;
  localparam int unsigned CW = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic start, ready, sel, ready_rnd;

  logic          a_start, a_busy, a_done, a_err, a_rd, a_bvalid, a_blast;
  logic [AW-1:0] a_addr;
  logic [63:0]   a_rdata;
  logic [31:0]   a_bdata;
  logic          b_start, b_busy, b_done, b_err, b_rd, b_bvalid, b_blast;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_rdata;
  logic [31:0]   b_bdata;

  assign a_start = start & ~sel;
  assign b_start = start & sel;

  results_streamer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(64), .BUS_WIDTH(32), .COUNT_WIDTH(CW)) dut_a (
    .CLK(CLK), .RST(RST), .Start(a_start), .Busy(a_busy), .Done(a_done), .Error(a_err),
    .RAM_Address(a_addr), .RAM_Read_En(a_rd), .RAM_Data(a_rdata),
    .Bus_Data(a_bdata), .Bus_Valid(a_bvalid), .Bus_Ready(ready), .Bus_Last(a_blast));

  results_streamer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .BUS_WIDTH(32), .COUNT_WIDTH(CW)) dut_b (
    .CLK(CLK), .RST(RST), .Start(b_start), .Busy(b_busy), .Done(b_done), .Error(b_err),
    .RAM_Address(b_addr), .RAM_Read_En(b_rd), .RAM_Data(b_rdata),
    .Bus_Data(b_bdata), .Bus_Valid(b_bvalid), .Bus_Ready(ready), .Bus_Last(b_blast));

  logic [63:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  // One-cycle read latency RAM models.
  always @(posedge CLK) begin
    if (a_rd) a_rdata <= mem_a[a_addr[5:0]];
    if (b_rd) b_rdata <= mem_b[b_addr[5:0]];
  end

  logic        m_valid, m_last, m_done, m_busy, m_err;
  logic [31:0] m_data;
  assign m_valid = sel ? b_bvalid : a_bvalid;
  assign m_last  = sel ? b_blast  : a_blast;
  assign m_data  = sel ? b_bdata  : a_bdata;
  assign m_done  = sel ? b_done   : a_done;
  assign m_busy  = sel ? b_busy   : a_busy;
  assign m_err   = sel ? b_err    : a_err;

  typedef struct { logic [31:0] data; logic last; } beat_t;
  beat_t         exp_q [$];
  logic [AW-1:0] rd_log [$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, start_cyc, first_valid_cyc, last_hs_cyc, done_cyc;
  int beats_seen, done_cnt, exp_n;
  bit exp_ovf;
  bit stall_prev = 0;
  logic [31:0] prev_data;
  logic        prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Ready driver: always ready, or a random 50% pattern.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1 ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Bus monitor: stall stability, scoreboard pop and Done tracking.
  always @(negedge CLK) begin
    if (RST) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(m_valid), 64'd1);
        check("stall_data", 64'(m_data), 64'(prev_data));
        check("stall_last", 64'(m_last), 64'(prev_last));
      end
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && ready) begin
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", 64'(m_data), 64'(e.data));
          check("beat_last", 64'(m_last), 64'(e.last));
        end
        beats_seen++;
        last_hs_cyc = cyc;
      end
      stall_prev = m_valid && !ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (sel && b_rd) rd_log.push_back(b_addr);
    end
  end

  function automatic logic [63:0] word_at(input int a);
    return sel ? {32'h0, mem_b[a & 63]} : mem_a[a & 63];
  endfunction

  task automatic push_word(input logic [63:0] w, input bit last);
    int nb;
    beat_t bt;
    nb = sel ? 1 : 2;
    for (int b = 0; b < nb; b++) begin
      bt.data = w[b*32 +: 32];
      bt.last = last && (b == nb - 1);
      exp_q.push_back(bt);
      exp_n++;
    end
  endtask

  task automatic fill(input logic [31:0] hi);
    for (int i = 0; i < 64; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    for (int t = 0; t < 7; t++) begin
      mem_a[3+t] = {hi, 32'hA0 + 32'(t)};
      mem_b[3+t] = 32'hA0 + 32'(t);
    end
    for (int k = 0; k < 40; k++) begin
      mem_a[10+k] = {32'h0, 32'hB000 + 32'(k)};
      mem_b[10+k] = 32'hB000 + 32'(k);
    end
  endtask

  // Write the count words and build the expected beat stream.
  task automatic prep(input logic [63:0] ntw, input logic [63:0] nxw);
    int nt, nx;
    exp_ovf = ((ntw >> CW) != 0) || ((nxw >> CW) != 0);
    nt = exp_ovf ? 0 : int'(ntw[CW-1:0]);
    nx = int'(nxw[CW-1:0]);
    if (sel) begin mem_b[1] = ntw[31:0]; mem_b[2] = nxw[31:0]; end
    else     begin mem_a[1] = ntw;       mem_a[2] = nxw;       end
    exp_q.delete();
    rd_log.delete();
    exp_n = 0; beats_seen = 0; done_cnt = 0;
    first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    for (int t = 0; t < nt; t++) begin
      push_word(word_at(3 + t), (t == nt - 1) && (nx == 0));
      for (int j = 0; j < nx; j++)
        push_word(word_at(10 + t*nx + j), (t == nt - 1) && (j == nx - 1));
    end
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1; start_cyc = cyc;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic run(input logic [63:0] ntw, input logic [63:0] nxw, input bit rnd,
                     input int poke_at, input string tag);
    int n;
    prep(ntw, nxw);
    ready_rnd = rnd;
    pulse_start();
    if (poke_at > 1) begin
      repeat (poke_at - 1) @(posedge CLK);
      #1 start = 1'b1;
      @(posedge CLK); #1 start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 600) begin @(posedge CLK); n++; end
    repeat (4) @(posedge CLK);
    #1;
    check({tag, " beats"}, 64'(beats_seen), 64'(exp_n));
    check({tag, " leftover"}, 64'(exp_q.size()), 64'd0);
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " error"}, 64'(m_err), 64'(exp_ovf));
    check({tag, " busy_after"}, 64'(m_busy), 64'd0);
    if (exp_n > 0) begin
      check({tag, " first_valid_lat"}, 64'(first_valid_cyc - start_cyc), 64'd6);
      check({tag, " done_after_last"}, 64'(done_cyc - last_hs_cyc), 64'd1);
    end else begin
      check({tag, " no_valid"}, 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      check({tag, " done_lat"}, 64'(done_cyc - start_cyc), 64'd4);
    end
    ready_rnd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [AW-1:0] exp_rd [5];
    RST = 1'b1; start = 1'b0; sel = 1'b0; ready_rnd = 1'b0;
    first_valid_cyc = -1; beats_seen = 0; done_cnt = 0;
    fill(32'h0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst busy", 64'(a_busy), 64'd0);
    check("rst done", 64'(a_done), 64'd0);
    check("rst error", 64'(a_err), 64'd0);
    check("rst rd_en", 64'(a_rd), 64'd0);
    check("rst addr", 64'(a_addr), 64'd0);
    check("rst valid", 64'(a_bvalid), 64'd0);
    check("rst last", 64'(a_blast), 64'd0);
    check("rst data", 64'(a_bdata), 64'd0);
    check("rst b valid", 64'(b_bvalid), 64'd0);
    @(posedge CLK); #1 RST = 1'b0;

    run(64'd2, 64'd3, 1'b0, 0, "basic");
    run(64'd2, 64'd3, 1'b1, 0, "stall");
    run(64'd0, 64'd3, 1'b0, 4, "nt0");
    fill(32'hC0DE_0000);
    run(64'd3, 64'd0, 1'b0, 0, "nx0");
    fill(32'h0);
    run(64'h100, 64'd3, 1'b0, 0, "ovf_nt");
    run(64'd2, 64'd3, 1'b1, 0, "clear_err");
    run(64'd2, 64'h1_0000_0003, 1'b0, 0, "ovf_nx");

    // Abort with RST while the fourth beat is on the bus.
    prep(64'd2, 64'd3);
    pulse_start();
    n = 0;
    while (beats_seen < 3 && n < 200) begin @(posedge CLK); n++; end
    #1 RST = 1'b1;
    @(posedge CLK); #1;
    check("abort valid", 64'(a_bvalid), 64'd0);
    check("abort busy", 64'(a_busy), 64'd0);
    check("abort done", 64'(a_done), 64'd0);
    RST = 1'b0;
    repeat (4) @(posedge CLK); #1;
    check("abort done_count", 64'(done_cnt), 64'd0);
    check("abort beats", 64'(beats_seen), 64'd3);
    run(64'd2, 64'd3, 1'b0, 0, "replay");

    // Single-beat instance, with Start pulsed mid-transfer.
    sel = 1'b1;
    run(64'd1, 64'd2, 1'b0, 8, "one_beat");
    exp_rd[0] = 13'd1; exp_rd[1] = 13'd2; exp_rd[2] = 13'd3; exp_rd[3] = 13'd10; exp_rd[4] = 13'd11;
    check("one_beat reads", 64'(rd_log.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      if (i < rd_log.size()) check($sformatf("one_beat read%0d", i), 64'(rd_log[i]), 64'(exp_rd[i]));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
